pio_infra_tx: RTL and testbench

Avalon-MM slave that drives the infrared beam-break emitter with a modulated carrier. The matching input-side PIO samples the receiver and captures falling edges. This block generates carrier bursts (mark) separated by silent gaps (space), either as a single one-shot burst or continuously. It raises a maskable interrupt when a one-shot burst completes and sits on the same Nios II data bus as the receiver PIO.

---
 rtl/pio_infra_tx.sv | 213 +++++++++++++++++++++
 tb/tb_pio_infra_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_infra_tx.sv
// Avalon-MM infrared emitter PIO: generates carrier bursts (mark) separated by
// silent gaps (space), one-shot or continuous, with a maskable completion irq.
module pio_infra_tx #(
    parameter logic [15:0] DIV_RESET = 16'd657,
    parameter logic [15:0] ON_RESET  = 16'd10,
    parameter logic [15:0] OFF_RESET = 16'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        out_port
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        cont_q, cont_d;
    logic        mask_q, mask_d;
    logic        done_q, done_d;
    logic [15:0] div_q, div_d;
    logic [15:0] on_q, on_d;
    logic [15:0] off_q, off_d;
    logic [15:0] div_sh_q, div_sh_d;
    logic [15:0] on_sh_q, on_sh_d;
    logic [15:0] off_sh_q, off_sh_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] per_q, per_d;
    logic        ph_q, ph_d;
    logic        out_q, out_d;
    logic        irq_q, irq_d;
    logic [15:0] rd_q, rd_d;

    logic        wr, ctrl_wr, status_wr, stop;
    logic        half_end, period_end, mark_last, space_last;
    logic [15:0] pre_nx, per_nx;
    logic        ph_nx;
    logic        enter, finish, done_set;

    // ph_q=0 is the lit half of a carrier period, ph_q=1 the dark half.
    assign half_end   = (pre_q == div_sh_q);
    assign period_end = half_end & ph_q;
    assign pre_nx     = half_end ? '0 : pre_q + 16'd1;
    assign ph_nx      = half_end ? ~ph_q : ph_q;
    assign per_nx     = period_end ? per_q + 16'd1 : per_q;
    assign mark_last  = (on_sh_q == '0) || (period_end && (per_q == on_sh_q - 16'd1));
    assign space_last = (off_sh_q == '0) || (period_end && (per_q == off_sh_q - 16'd1));

    always_comb begin
        wr        = chipselect & ~write_n;
        ctrl_wr   = wr & (address == 3'd0);
        status_wr = wr & (address == 3'd4);
        stop      = ctrl_wr & ~writedata[0];

        state_d  = state_q;
        en_d     = en_q;
        cont_d   = cont_q;
        mask_d   = mask_q;
        div_d    = div_q;
        on_d     = on_q;
        off_d    = off_q;
        div_sh_d = div_sh_q;
        on_sh_d  = on_sh_q;
        off_sh_d = off_sh_q;
        pre_d    = pre_q;
        ph_d     = ph_q;
        per_d    = per_q;
        out_d    = 1'b0;
        enter    = 1'b0;
        finish   = 1'b0;
        done_set = 1'b0;

        if (ctrl_wr) begin
            cont_d = writedata[1];
            mask_d = writedata[2];
        end
        if (wr && address == 3'd1) div_d = writedata;
        if (wr && address == 3'd2) on_d  = writedata;
        if (wr && address == 3'd3) off_d = writedata;

        case (state_q)
            IDLE: enter = ctrl_wr & writedata[0];
            MARK: begin
                if (mark_last) begin
                    pre_d = '0;
                    ph_d  = 1'b0;
                    per_d = '0;
                    if (off_sh_q != '0) state_d = SPACE;
                    else                finish  = 1'b1;
                end else begin
                    pre_d = pre_nx;
                    ph_d  = ph_nx;
                    per_d = per_nx;
                    out_d = ~ph_nx;
                end
            end
            SPACE: begin
                if (space_last) begin
                    pre_d  = '0;
                    ph_d   = 1'b0;
                    per_d  = '0;
                    finish = 1'b1;
                end else begin
                    pre_d = pre_nx;
                    ph_d  = ph_nx;
                    per_d = per_nx;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            if (cont_q) begin
                enter = 1'b1;
            end else begin
                state_d  = IDLE;
                en_d     = 1'b0;
                done_set = 1'b1;
            end
        end

        // Zero-length phases are skipped at entry; ON=OFF=0 still occupies one MARK cycle.
        if (enter) begin
            div_sh_d = div_q;
            on_sh_d  = on_q;
            off_sh_d = off_q;
            pre_d    = '0;
            ph_d     = 1'b0;
            per_d    = '0;
            en_d     = 1'b1;
            if (on_q != '0) begin
                state_d = MARK;
                out_d   = 1'b1;
            end else if (off_q != '0) begin
                state_d = SPACE;
            end else begin
                state_d = MARK;
            end
        end

        if (stop) begin
            state_d  = IDLE;
            en_d     = 1'b0;
            out_d    = 1'b0;
            done_set = 1'b0;
            pre_d    = '0;
            ph_d     = 1'b0;
            per_d    = '0;
        end

        done_d = done_set | (done_q & ~status_wr);
        irq_d  = done_d & mask_d;

        case (address)
            3'd0:    rd_d = {13'd0, mask_q, cont_q, en_q};
            3'd1:    rd_d = div_q;
            3'd2:    rd_d = on_q;
            3'd3:    rd_d = off_q;
            3'd4:    rd_d = {14'd0, done_q, state_q != IDLE};
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            cont_q   <= 1'b0;
            mask_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= DIV_RESET;
            on_q     <= ON_RESET;
            off_q    <= OFF_RESET;
            div_sh_q <= DIV_RESET;
            on_sh_q  <= ON_RESET;
            off_sh_q <= OFF_RESET;
            pre_q    <= '0;
            ph_q     <= 1'b0;
            per_q    <= '0;
            out_q    <= 1'b0;
            irq_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            cont_q   <= cont_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            div_q    <= div_d;
            on_q     <= on_d;
            off_q    <= off_d;
            div_sh_q <= div_sh_d;
            on_sh_q  <= on_sh_d;
            off_sh_q <= off_sh_d;
            pre_q    <= pre_d;
            ph_q     <= ph_d;
            per_q    <= per_d;
            out_q    <= out_d;
            irq_q    <= irq_d;
            rd_q     <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_pio_infra_tx.sv
// Bench for pio_infra_tx: waveform-queue reference model checked every cycle,
// plus directed scenarios with literal expected waveforms and flags.
module tb_pio_infra_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic        out_port;

    pio_infra_tx #(
        .DIV_RESET(16'd657),
        .ON_RESET (16'd10),
        .OFF_RESET(16'd10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is the list of emitter levels it will produce.
    bit          m_valid = 1'b0;
    logic        m_busy, m_out, m_en, m_cont, m_mask, m_done, m_irq;
    logic [15:0] m_div, m_on, m_off, m_rd;
    bit          mq[$];

    task automatic m_load();
        int unsigned h;
        h = int'(m_div) + 1;
        mq.delete();
        for (int unsigned p = 0; p < m_on; p++) begin
            for (int unsigned i = 0; i < h; i++) mq.push_back(1'b1);
            for (int unsigned i = 0; i < h; i++) mq.push_back(1'b0);
        end
        for (int unsigned i = 0; i < 2 * h * m_off; i++) mq.push_back(1'b0);
        if (mq.size() == 0) mq.push_back(1'b0);
    endtask

    always @(posedge clk) begin : model
        bit          w, fin, start, dset, was_busy;
        logic [15:0] rd;
        if (reset) begin
            m_valid = 1'b1;
            m_busy = 0; m_out = 0; m_en = 0; m_cont = 0; m_mask = 0;
            m_done = 0; m_irq = 0; m_rd = '0;
            m_div = 16'd657; m_on = 16'd10; m_off = 16'd10;
            mq.delete();
        end else begin
            w = chipselect && !write_n;
            fin = 0; start = 0; dset = 0; was_busy = m_busy;
            case (address)
                3'd0:    rd = {13'd0, m_mask, m_cont, m_en};
                3'd1:    rd = m_div;
                3'd2:    rd = m_on;
                3'd3:    rd = m_off;
                3'd4:    rd = {14'd0, m_done, m_busy};
                default: rd = '0;
            endcase
            if (m_busy) begin
                if (mq.size() == 0) fin = 1;
                else                m_out = mq.pop_front();
            end
            if (fin) begin
                if (m_cont) start = 1;
                else begin m_busy = 0; m_out = 0; m_en = 0; dset = 1; end
            end
            if (!was_busy && w && address == 3'd0 && writedata[0]) start = 1;
            if (start) begin
                m_load();
                m_out = mq.pop_front();
                m_busy = 1; m_en = 1;
            end
            if (w && address == 3'd0 && !writedata[0]) begin
                m_busy = 0; m_out = 0; m_en = 0; dset = 0;
                mq.delete();
            end
            if (w) begin
                case (address)
                    3'd0: begin m_cont = writedata[1]; m_mask = writedata[2]; end
                    3'd1: m_div = writedata;
                    3'd2: m_on  = writedata;
                    3'd3: m_off = writedata;
                    default: ;
                endcase
            end
            m_done = dset | ((w && address == 3'd4) ? 1'b0 : m_done);
            m_irq  = m_done & m_mask;
            m_rd   = rd;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out_port", {31'd0, out_port}, {31'd0, m_out});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("readdata", {16'd0, readdata}, {16'd0, m_rd});
        end
    end

    // Emitter log indexed by posedge count, for literal waveform checks.
    int cyc = 0;
    bit outlog [0:4095];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 4096) outlog[cyc] <= out_port;

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic grab(input int s, input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], outlog[s + i]};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        logic [31:0] v;

        repeat (3) @(negedge clk);
        chk("rst_out", {31'd0, out_port}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_readdata", {16'd0, readdata}, 32'd0);
        reset = 1'b0;
        address = 3'd1; @(negedge clk);
        chk("rd_div_reset", {16'd0, readdata}, 32'd657);
        address = 3'd2; @(negedge clk);
        chk("rd_on_reset", {16'd0, readdata}, 32'd10);

        // One-shot: DIV=1 ON=3 OFF=2
        wr(3'd1, 16'd1); wr(3'd2, 16'd3); wr(3'd3, 16'd2);
        wr(3'd0, 16'h5); s = cyc;
        idle(20);
        chk("os_irq_at_21", {31'd0, irq}, 32'd1);
        grab(s, 20, v);
        chk("os_wave", v, 32'h000CCC00);
        address = 3'd4; @(negedge clk);
        chk("os_status", {16'd0, readdata}, 32'd2);
        wr(3'd4, 16'd0);
        chk("os_irq_clear", {31'd0, irq}, 32'd0);

        // Continuous: DIV=0 ON=2 OFF=1
        wr(3'd1, 16'd0); wr(3'd2, 16'd2); wr(3'd3, 16'd1);
        wr(3'd0, 16'h3); s = cyc;
        idle(12);
        grab(s, 12, v);
        chk("cont_wave", v, 32'h00000A28);
        wr(3'd0, 16'h7);
        idle(6);
        wr(3'd0, 16'h0);
        chk("cont_stop_out", {31'd0, out_port}, 32'd0);
        address = 3'd4; @(negedge clk);
        chk("cont_stop_status", {16'd0, readdata}, 32'd0);

        // Mid-burst reprogram of ON, then drop continuous
        wr(3'd1, 16'd1); wr(3'd2, 16'd4); wr(3'd3, 16'd1);
        wr(3'd0, 16'h3); s = cyc;
        wr(3'd2, 16'd1);
        idle(30);
        grab(s, 28, v);
        chk("reprog_wave", v, 32'h0CCCC0C0);
        wr(3'd0, 16'h5);
        idle(30);
        address = 3'd4; @(negedge clk);
        chk("cont_to_oneshot_status", {16'd0, readdata}, 32'd2);
        chk("cont_to_oneshot_irq", {31'd0, irq}, 32'd1);
        wr(3'd4, 16'd0);

        // Zero counts
        wr(3'd2, 16'd0); wr(3'd3, 16'd0);
        wr(3'd0, 16'h5);
        chk("zero_out", {31'd0, out_port}, 32'd0);
        chk("zero_irq_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("zero_irq", {31'd0, irq}, 32'd1);
        address = 3'd4; @(negedge clk);
        chk("zero_status", {16'd0, readdata}, 32'd2);
        wr(3'd4, 16'd0);

        // Race: STATUS write on the completion edge
        wr(3'd1, 16'd0); wr(3'd2, 16'd1); wr(3'd3, 16'd1);
        wr(3'd0, 16'h5);
        idle(3);
        wr(3'd4, 16'd0);
        chk("race_status_set_wins", {31'd0, irq}, 32'd1);
        wr(3'd4, 16'd0);
        chk("race_status_cleared", {31'd0, irq}, 32'd0);

        // Race: stop write on the completion edge
        wr(3'd0, 16'h5);
        idle(3);
        wr(3'd0, 16'h0);
        chk("race_stop_irq", {31'd0, irq}, 32'd0);
        address = 3'd4; @(negedge clk);
        chk("race_stop_status", {16'd0, readdata}, 32'd0);

        // Reset mid-MARK
        wr(3'd1, 16'd1); wr(3'd2, 16'd3); wr(3'd3, 16'd2);
        address = 3'd1;
        wr(3'd0, 16'h5);
        idle(2);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("rst_mid_out", {31'd0, out_port}, 32'd0);
        chk("rst_mid_readdata", {16'd0, readdata}, 32'd0);
        address = 3'd0; @(negedge clk);
        chk("rst_mid_ctrl", {16'd0, readdata}, 32'd0);
        address = 3'd1; @(negedge clk);
        chk("rst_mid_div", {16'd0, readdata}, 32'd657);

        // Unmapped addresses
        wr(3'd5, 16'hFFFF);
        for (int a = 5; a < 8; a++) begin
            address = 3'(a); @(negedge clk);
            chk("rd_unmapped", {16'd0, readdata}, 32'd0);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
